// File: rtl/rv_mem_arbiter_pkg.sv
// rv_mem_pkg: memory request constants, field widths, request struct (addr/data/req_type/len/mask/cid) and arbiter output-stage state
package rv_mem_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_CID_W = 5;
  localparam logic [1:0] MEM_REQ_WR = 2'b01;
  localparam logic [1:0] MEM_REQ_RD = 2'b10;
  localparam logic [3:0] MEM_LEN_4B = 4'h0;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic [1:0] req_type;
    logic [3:0] len;
    logic [3:0] mask;
    logic [MEM_CID_W-1:0] cid;
  } mem_req_t;
  typedef enum logic {IDLE, HOLD} arb_state_e;
endpackage

// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if: req/rsp handshake bundle; master drives req_valid/req/rsp_ready, slave drives req_ready/rsp_vld/rsp_data/rsp_cid
interface rv_mem_arbiter_if;
  import rv_mem_pkg::*;
  logic req_valid;
  logic req_ready;
  mem_req_t req;
  logic rsp_vld;
  logic rsp_ready;
  logic [MEM_DATA_W-1:0] rsp_data;
  logic [MEM_CID_W-1:0] rsp_cid;
  modport master(output req_valid, req, rsp_ready, input req_ready, rsp_vld, rsp_data, rsp_cid);
  modport slave(input req_valid, req, rsp_ready, output req_ready, rsp_vld, rsp_data, rsp_cid);
endinterface

// File: rtl/rv_sync_fifo.sv
// rv_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers; ports sclk, rst, push/wr_data in, pop in, rd_data/empty out; a push into a full FIFO is taken only alongside a pop
module rv_sync_fifo #(
  parameter int W = 1,
  parameter int D = 4
) (
  input  logic         sclk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [AW:0] wptr, rptr;
  logic [W-1:0] store [D];
  logic full, wr, rd;
  always_comb begin
    empty = wptr == rptr;
    full = wptr == {~rptr[AW], rptr[AW-1:0]};
    rd = pop & ~empty;
    wr = push & (~full | rd);
    rd_data = store[rptr[AW-1:0]];
  end
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + {{AW{1'b0}}, wr};
      rptr <= rptr + {{AW{1'b0}}, rd};
    end
  end
  always_ff @(posedge sclk) begin
    if (wr) store[wptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one memory port between requesters r0 (fetch) and r1 (load/store) with registered grants and in-order response routing; ports sclk, rst, r0/r1 (slave), mem (master), outstanding_cnt, rsp_orphan
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                               sclk,
  input  logic                               rst,
  rv_mem_arbiter_if.slave                    r0,
  rv_mem_arbiter_if.slave                    r1,
  rv_mem_arbiter_if.master                   mem,
  output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding_cnt,
  output logic                               rsp_orphan
);
  localparam int CW = $clog2(OUTSTANDING+1);
  arb_state_e state, state_n;
  logic head, empty, pop, slot, grant, sel1, last_grant;
  logic [CW-1:0] cnt_after;
  always_comb begin
    mem.rsp_ready = ~empty & (head ? r1.rsp_ready : r0.rsp_ready);
    pop = mem.rsp_vld & mem.rsp_ready;
    cnt_after = outstanding_cnt - CW'(pop);
    slot = ~rst & (state == IDLE | mem.req_ready) & (cnt_after < CW'(OUTSTANDING));
    sel1 = FIXED_PRIO != 0 ? r1.req_valid : r1.req_valid & (~r0.req_valid | ~last_grant);
    grant = slot & (r0.req_valid | r1.req_valid);
    r0.req_ready = grant & ~sel1;
    r1.req_ready = grant & sel1;
    r0.rsp_vld = mem.rsp_vld & ~empty & ~head;
    r1.rsp_vld = mem.rsp_vld & ~empty & head;
    r0.rsp_data = mem.rsp_data;
    r1.rsp_data = mem.rsp_data;
    r0.rsp_cid = mem.rsp_cid;
    r1.rsp_cid = mem.rsp_cid;
  end
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = grant || (state == HOLD && !mem.req_ready) ? HOLD : IDLE;
  end
  always_comb begin
    mem.req_valid = state == HOLD;
  end
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      mem.req <= '0;
      last_grant <= 1'b1;
      outstanding_cnt <= '0;
      rsp_orphan <= 1'b0;
    end else begin
      if (grant) begin
        mem.req <= sel1 ? r1.req : r0.req;
        last_grant <= sel1;
      end
      outstanding_cnt <= cnt_after + CW'(grant);
      rsp_orphan <= rsp_orphan | (mem.rsp_vld & empty);
    end
  end
  rv_sync_fifo #(.W(1), .D(OUTSTANDING)) u_order (
    .sclk(sclk),
    .rst(rst),
    .push(grant),
    .pop(pop),
    .wr_data(sel1),
    .rd_data(head),
    .empty(empty)
  );
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed stimulus with a queue-based reference model checked every cycle plus literal expectations
module tb_rv_mem_arbiter;
  import rv_mem_pkg::*;
  localparam int OUT = 4;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] cnt, f_cnt;
  logic orphan, f_orphan;
  int checks = 0;
  int passed = 0;
  rv_mem_arbiter_if r0_i(), r1_i(), mem_i(), f0_i(), f1_i(), fm_i();
  rv_mem_arbiter #(.OUTSTANDING(OUT), .FIXED_PRIO(0)) dut (
    .sclk(sclk), .rst(rst), .r0(r0_i), .r1(r1_i), .mem(mem_i),
    .outstanding_cnt(cnt), .rsp_orphan(orphan)
  );
  rv_mem_arbiter #(.OUTSTANDING(OUT), .FIXED_PRIO(1)) dut_fp (
    .sclk(sclk), .rst(rst), .r0(f0_i), .r1(f1_i), .mem(fm_i),
    .outstanding_cnt(f_cnt), .rsp_orphan(f_orphan)
  );
  always #5 sclk = ~sclk;
  task automatic chk(string name, logic [79:0] got, logic [79:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  function automatic mem_req_t mk(logic [31:0] a, logic [4:0] c);
    mk = '{addr: a, data: ~a, req_type: MEM_REQ_RD, len: MEM_LEN_4B, mask: 4'hf, cid: c};
  endfunction
  function automatic int winr();
    winr = r1_i.req_ready ? 1 : r0_i.req_ready ? 0 : -1;
  endfunction
  function automatic int fwinr();
    fwinr = f1_i.req_ready ? 1 : f0_i.req_ready ? 0 : -1;
  endfunction
  task automatic step();
    @(posedge sclk);
    #1;
  endtask
  task automatic at_neg();
    @(negedge sclk);
  endtask
  int q[$];
  logic exp_valid = 1'b0;
  mem_req_t exp_req = '0;
  int last = 1;
  logic exp_orphan = 1'b0;
  always @(negedge sclk) begin
    int win;
    logic free, hr, pop, to0, to1;
    if (rst) begin
      chk("rst_mem_req_valid", mem_i.req_valid, 0);
      chk("rst_mem_req", mem_i.req, 0);
      chk("rst_r0_req_ready", r0_i.req_ready, 0);
      chk("rst_r1_req_ready", r1_i.req_ready, 0);
      chk("rst_rsp_vld", {r0_i.rsp_vld, r1_i.rsp_vld}, 0);
      chk("rst_mem_rsp_ready", mem_i.rsp_ready, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_orphan", orphan, 0);
      q.delete();
      exp_valid = 1'b0;
      exp_req = '0;
      last = 1;
      exp_orphan = 1'b0;
    end else begin
      to0 = q.size() > 0 && q[0] == 0;
      to1 = q.size() > 0 && q[0] == 1;
      hr = (to0 && r0_i.rsp_ready) || (to1 && r1_i.rsp_ready);
      pop = hr && mem_i.rsp_vld;
      free = (!exp_valid || mem_i.req_ready) && (q.size() - (pop ? 1 : 0) < OUT);
      if (r0_i.req_valid && r1_i.req_valid) win = last == 0 ? 1 : 0;
      else win = r1_i.req_valid ? 1 : r0_i.req_valid ? 0 : -1;
      if (!free) win = -1;
      chk("m_mem_req_valid", mem_i.req_valid, exp_valid);
      chk("m_mem_req", mem_i.req, exp_req);
      chk("m_r0_req_ready", r0_i.req_ready, win == 0);
      chk("m_r1_req_ready", r1_i.req_ready, win == 1);
      chk("m_mem_rsp_ready", mem_i.rsp_ready, hr);
      chk("m_r0_rsp_vld", r0_i.rsp_vld, mem_i.rsp_vld && to0);
      chk("m_r1_rsp_vld", r1_i.rsp_vld, mem_i.rsp_vld && to1);
      chk("m_r0_rsp", {r0_i.rsp_data, r0_i.rsp_cid}, {mem_i.rsp_data, mem_i.rsp_cid});
      chk("m_r1_rsp", {r1_i.rsp_data, r1_i.rsp_cid}, {mem_i.rsp_data, mem_i.rsp_cid});
      chk("m_cnt", cnt, q.size());
      chk("m_orphan", orphan, exp_orphan);
      if (mem_i.rsp_vld && q.size() == 0) exp_orphan = 1'b1;
      if (pop) void'(q.pop_front());
      if (win >= 0) begin
        q.push_back(win);
        exp_req = win == 1 ? r1_i.req : r0_i.req;
        exp_valid = 1'b1;
        last = win;
      end else if (mem_i.req_ready) exp_valid = 1'b0;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    r0_i.req_valid = 0; r0_i.req = '0; r0_i.rsp_ready = 1;
    r1_i.req_valid = 0; r1_i.req = '0; r1_i.rsp_ready = 1;
    f0_i.req_valid = 0; f0_i.req = '0; f0_i.rsp_ready = 1;
    f1_i.req_valid = 0; f1_i.req = '0; f1_i.rsp_ready = 1;
    mem_i.req_ready = 1; mem_i.rsp_vld = 0; mem_i.rsp_data = '0; mem_i.rsp_cid = '0;
    fm_i.req_ready = 1; fm_i.rsp_vld = 0; fm_i.rsp_data = '0; fm_i.rsp_cid = '0;
    repeat (2) @(posedge sclk);
    #1 rst = 0;
    r0_i.req_valid = 1; r0_i.req = mk(32'h100, 5'd3);
    at_neg(); chk("t1_r0_ready", r0_i.req_ready, 1); chk("t1_cnt0", cnt, 0);
    step(); r0_i.req_valid = 0;
    at_neg(); chk("t1_valid", mem_i.req_valid, 1); chk("t1_addr", mem_i.req.addr, 32'h100);
    chk("t1_cid", mem_i.req.cid, 5'd3); chk("t1_cnt1", cnt, 1);
    step(); mem_i.rsp_vld = 1; mem_i.rsp_data = 32'hDEADBEEF; mem_i.rsp_cid = 5'd3;
    at_neg(); chk("t1_r0_rsp_vld", r0_i.rsp_vld, 1); chk("t1_r1_rsp_vld", r1_i.rsp_vld, 0);
    chk("t1_rsp_data", r0_i.rsp_data, 32'hDEADBEEF); chk("t1_rsp_cid", r0_i.rsp_cid, 5'd3);
    step(); mem_i.rsp_vld = 0;
    at_neg(); chk("t1_cnt_back", cnt, 0); chk("t1_idle", mem_i.req_valid, 0);
    step(); rst = 1;
    step(); rst = 0;
    r0_i.req_valid = 1; r0_i.req = mk(32'h10, 5'd1);
    r1_i.req_valid = 1; r1_i.req = mk(32'h20, 5'd2);
    f0_i.req_valid = 1; f0_i.req = mk(32'h10, 5'd1);
    f1_i.req_valid = 1; f1_i.req = mk(32'h20, 5'd2);
    for (int i = 0; i < 4; i++) begin
      at_neg(); chk($sformatf("rr_grant%0d", i), winr(), i % 2); chk($sformatf("fp_grant%0d", i), fwinr(), 1);
      step();
    end
    r0_i.req_valid = 0; r1_i.req_valid = 0; f0_i.req_valid = 0; f1_i.req_valid = 0;
    at_neg(); chk("rr_cnt4", cnt, 4); chk("fp_cnt4", f_cnt, 4);
    step(); mem_i.rsp_vld = 1;
    for (int i = 0; i < 4; i++) begin
      mem_i.rsp_data = 32'hA000 + i; mem_i.rsp_cid = 5'(i % 2 + 1);
      at_neg(); chk($sformatf("rr_rsp_r0_%0d", i), r0_i.rsp_vld, i % 2 == 0);
      chk($sformatf("rr_rsp_r1_%0d", i), r1_i.rsp_vld, i % 2 == 1);
      step();
    end
    mem_i.rsp_vld = 0;
    at_neg(); chk("cs_cnt0", cnt, 0);
    step(); r1_i.req_valid = 1; r1_i.req = mk(32'h300, 5'd7);
    for (int i = 0; i < 4; i++) begin
      at_neg(); chk($sformatf("cs_grant%0d", i), r1_i.req_ready, 1);
      step();
    end
    at_neg(); chk("cs_stall", r1_i.req_ready, 0); chk("cs_cnt4", cnt, 4);
    step(); mem_i.rsp_vld = 1; mem_i.rsp_data = 32'h5; mem_i.rsp_cid = 5'd7;
    at_neg(); chk("cs_release", r1_i.req_ready, 1); chk("cs_pop", mem_i.rsp_ready, 1); chk("cs_cnt_hold", cnt, 4);
    step(); r1_i.req_valid = 0;
    repeat (4) step();
    mem_i.rsp_vld = 0;
    r0_i.req_valid = 1; r0_i.req = mk(32'h200, 5'd4); mem_i.req_ready = 0;
    at_neg(); chk("cs_drained", cnt, 0); chk("bp_g0", r0_i.req_ready, 1);
    step(); r0_i.req_valid = 0; r1_i.req_valid = 1; r1_i.req = mk(32'h300, 5'd5);
    for (int i = 0; i < 3; i++) begin
      at_neg(); chk("bp_hold_valid", mem_i.req_valid, 1); chk("bp_hold_req", mem_i.req, mk(32'h200, 5'd4));
      chk("bp_r1_blocked", r1_i.req_ready, 0);
      step();
    end
    mem_i.req_ready = 1;
    at_neg(); chk("bp_g1", r1_i.req_ready, 1); chk("bp_addr0", mem_i.req.addr, 32'h200);
    step(); r1_i.req_valid = 0; r0_i.req_valid = 1; r0_i.req = mk(32'h400, 5'd6);
    at_neg(); chk("bp_addr1", mem_i.req.addr, 32'h300); chk("bp_g2", r0_i.req_ready, 1);
    step(); r0_i.req_valid = 0;
    at_neg(); chk("bp_addr2", mem_i.req.addr, 32'h400);
    step();
    at_neg(); chk("bp_cnt3", cnt, 3); chk("bp_idle", mem_i.req_valid, 0);
    step(); mem_i.rsp_vld = 1; r1_i.rsp_ready = 0; mem_i.rsp_data = 32'h1111; mem_i.rsp_cid = 5'd4;
    at_neg(); chk("rt_r0_first", r0_i.rsp_vld, 1); chk("rt_pop0", mem_i.rsp_ready, 1);
    step(); mem_i.rsp_data = 32'h2222; mem_i.rsp_cid = 5'd5;
    at_neg(); chk("rt_r1_vld", r1_i.rsp_vld, 1); chk("rt_r0_quiet", r0_i.rsp_vld, 0); chk("rt_bp", mem_i.rsp_ready, 0);
    step(); r1_i.rsp_ready = 1;
    at_neg(); chk("rt_pop1", mem_i.rsp_ready, 1); chk("rt_r1_cid", r1_i.rsp_cid, 5'd5);
    step(); mem_i.rsp_data = 32'h3333; mem_i.rsp_cid = 5'd6;
    at_neg(); chk("rt_r0_last", r0_i.rsp_vld, 1);
    step(); mem_i.rsp_vld = 0;
    at_neg(); chk("rt_cnt0", cnt, 0);
    step(); mem_i.rsp_vld = 1;
    at_neg(); chk("orph_ready", mem_i.rsp_ready, 0); chk("orph_rsp_vld", {r0_i.rsp_vld, r1_i.rsp_vld}, 0);
    chk("orph_before", orphan, 0);
    step(); mem_i.rsp_vld = 0;
    at_neg(); chk("orph_flag", orphan, 1);
    step(); r0_i.req_valid = 1; r0_i.req = mk(32'h500, 5'd8);
    step();
    step();
    at_neg(); chk("rs_cnt2", cnt, 2);
    step(); rst = 1;
    at_neg(); chk("rs_cnt", cnt, 0); chk("rs_valid", mem_i.req_valid, 0); chk("rs_orphan", orphan, 0);
    chk("rs_ready", r0_i.req_ready, 0); chk("rs_req", mem_i.req, 0); chk("rs_rsp_ready", mem_i.rsp_ready, 0);
    step(); rst = 0; r0_i.req_valid = 0;
    at_neg(); chk("post_cnt", cnt, 0);
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
